skew_feeder: RTL and testbench
==============================

// Module: skew_feeder
// PURPOSE
//  Downstream consumer of the N per-row 8-bit input FIFOs. Pops len words from every FIFO
//  with a diagonal skew (lane i starts i cycles after lane 0) and drives the west edge of the
//  systolic PE array with data plus per-lane valid. Global stall keeps the skew intact when
//  any FIFO runs dry.
// PARAMETERS
//  LANES   4   number of FIFO lanes / PE array rows
//  DATA_W  8   word width, matches FIFO dataOut
//  LEN_W   4   width of len; legal len 0..8 (FIFO depth 8)
// PORTS
//  clk        in   1             clock, rising edge
//  reset      in   1             asynchronous, active-high
//  start      in   1             1-cycle pulse, begin a burst; sampled only in IDLE
//  len        in   LEN_W         words per lane, sampled with start
//  fifo_empty in   LANES         empty flag of each lane FIFO
//  fifo_dout  in   LANES*DATA_W  FIFO dataOut, lane i at [i*DATA_W +: DATA_W]
//  fifo_rd    out  LANES         pop request per lane (combinational from state)
//  pe_data    out  LANES*DATA_W  registered word to PE row i, 0 when not valid
//  pe_valid   out  LANES         registered valid per lane
//  busy       out  1             high from cycle after accepted start until done
//  done       out  1             1-cycle pulse, burst complete
// BEHAVIOUR
//  - Reset (async): state=IDLE, t=0, len_q=0, rd_d=0; pe_data=0, pe_valid=0, busy=0, done=0,
//    fifo_rd=0. Reset mid-burst aborts instantly; FIFO contents are not restored.
//  - FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//    IDLE: start & len!=0 -> RUN, len_q<=len, t<=0. start & len==0 -> DONE (no pops).
//    start outside IDLE ignored.
//  - RUN: want[i] = (t >= i) && (t < i+len_q). stall = |(want & fifo_empty).
//    fifo_rd[i] = want[i] & ~stall & (state==RUN). No lane pops while stalled; t holds.
//    Otherwise t<=t+1; when t == len_q+LANES-2 and no stall (last issue) -> DRAIN.
//  - FIFO dataOut is valid the cycle after its rd: rd_d <= fifo_rd each cycle.
//    Every edge: pe_valid[i] <= rd_d[i]; pe_data lane i <= rd_d[i] ? fifo_dout lane i : 0.
//    Latency pop -> pe_valid = 2 cycles.
//  - DRAIN: 1 cycle, no pops (flushes rd_d). DONE: done=1 for 1 cycle -> IDLE.
//    The last pe_valid is asserted in the cycle done is high.
//  - busy = (state != IDLE).
//  - Stall cycles become a bubble (pe_valid=0) on every lane simultaneously. Lane-to-lane skew
//    stays exactly 1 cycle. PE array uses pe_valid as its enable.
//  - t width: LEN_W+clog2(LANES)+1 bits, no wrap for legal len. len>8 is illegal; behaviour
//    is unspecified but no hang (t is bounded by len_q+LANES-1).
//  - fifo_empty is only examined for lanes with want=1. Lanes outside their window never pop.
// TESTING
//  1 reset mid-RUN (t=2, LANES=4, len=3): all outputs 0 immediately, state IDLE;
//    next start accepted normally.
//  2 LANES=4, len=3, FIFOs never empty, start@c0: fifo_rd lane0 c1-c3, lane3 c4-c6;
//    pe_valid lane0 c3-c5, lane3 c6-c8; done@c8.
//  3 same as 2, lane2 empty during c3 only: no lane pops in c3; all lanes insert one bubble;
//    done@c9; data order per lane unchanged.
//  4 len=0 start: done pulse next cycle, fifo_rd never asserted, pe_valid stays 0.
//  5 start pulsed again while busy: ignored; exactly one done, pop count = LANES*len.
//  6 lane0 words 0x11,0x22,0x33: pe_data lane0 = 0x11,0x22,0x33 on consecutive valid cycles;
//    0x00 when pe_valid=0.

Source files
------------

// File: rtl/skew_feeder.sv
// Pops len words from each lane FIFO with a one-cycle-per-lane diagonal skew and feeds the
// west edge of the PE array; a single global stall keeps every lane aligned to the skew.
module skew_feeder #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  input  logic [LANES-1:0]          fifo_empty,
  input  logic [LANES*DATA_W-1:0]   fifo_dout,
  output logic [LANES-1:0]          fifo_rd,
  output logic [LANES*DATA_W-1:0]   pe_data,
  output logic [LANES-1:0]          pe_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int T_W = LEN_W + $clog2(LANES) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  logic [T_W-1:0]     t;
  logic [LEN_W-1:0]   len_q;
  logic [LANES-1:0]   rd_d;
  logic [LANES-1:0]   want;
  logic               stall;
  logic [T_W-1:0]     len_ext;
  logic [T_W-1:0]     last_t;
  logic               last_issue;

  assign len_ext = T_W'(len_q);
  assign last_t  = len_ext + T_W'(LANES) - T_W'(2);

  // Lane gi is inside its pop window for t in [gi, gi+len_q).
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_want
      if (gi == 0) begin : g_first
        assign want[gi] = (t < len_ext);
      end else begin : g_rest
        assign want[gi] = (t >= T_W'(gi)) && (t < T_W'(gi) + len_ext);
      end
    end
  endgenerate

  assign stall      = |(want & fifo_empty);
  assign last_issue = (t >= last_t);
  assign fifo_rd    = ((state == RUN) && !stall) ? want : '0;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      t     <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state <= RUN;
              len_q <= len;
              t     <= '0;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (!stall) begin
            t <= t + T_W'(1);
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO read data arrives one cycle after the pop, so the pop strobe is delayed to match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_d     <= '0;
      pe_valid <= '0;
      pe_data  <= '0;
    end else begin
      rd_d     <= fifo_rd;
      pe_valid <= rd_d;
      for (int i = 0; i < LANES; i++) begin
        pe_data[i*DATA_W +: DATA_W] <= rd_d[i] ? fifo_dout[i*DATA_W +: DATA_W] : '0;
      end
    end
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder: per-cycle vector table plus reset and data-order sequences
// against a behavioural FIFO model with registered read data.
module tb_skew_feeder;
  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int NROWS  = 22;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic [LANES-1:0]        fifo_empty;
  logic [LANES*DATA_W-1:0] fifo_dout;
  logic [LANES-1:0]        fifo_rd;
  logic [LANES*DATA_W-1:0] pe_data;
  logic [LANES-1:0]        pe_valid;
  logic                    busy;
  logic                    done;

  logic [DATA_W-1:0] dout_m [LANES] = '{default: 8'hAA};
  int rdptr   [LANES] = '{default: 0};
  int exp_idx [LANES] = '{default: 0};
  int pops     = 0;
  int done_cnt = 0;
  int total    = 0;
  int passed   = 0;

  typedef struct {
    logic             start;
    logic [LEN_W-1:0] len;
    logic [LANES-1:0] empty;
    logic [LANES-1:0] rd;
    logic [LANES-1:0] valid;
    logic             done;
    logic             busy;
  } vec_t;

  vec_t tbl [NROWS];

  skew_feeder #(.LANES(LANES), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
    .pe_data(pe_data), .pe_valid(pe_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word(input int lane, input int k);
    return DATA_W'((k + 1) * 17 + lane);
  endfunction

  // FIFO model: data word appears on dout the cycle after the pop.
  always @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (fifo_rd[i]) begin
        dout_m[i] <= word(i, rdptr[i]);
        rdptr[i]  <= rdptr[i] + 1;
      end
    end
    pops <= pops + $countones(fifo_rd);
    if (done) done_cnt <= done_cnt + 1;
  end

  always_comb begin
    fifo_dout = '0;
    for (int i = 0; i < LANES; i++) fifo_dout[i*DATA_W +: DATA_W] = dout_m[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Each valid word must be the next word popped from that lane, otherwise data is zero.
  task automatic check_data();
    logic [DATA_W-1:0] e;
    for (int i = 0; i < LANES; i++) begin
      if (pe_valid[i]) begin
        e = word(i, exp_idx[i]);
        exp_idx[i]++;
      end else begin
        e = '0;
      end
      chk($sformatf("pe_data[%0d]", i), 32'(pe_data[i*DATA_W +: DATA_W]), 32'(e));
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [3:0] l, input logic [3:0] e,
                              input logic [3:0] r, input logic [3:0] v,
                              input logic d, input logic b);
    vec_t x;
    x.start = s; x.len = l; x.empty = e; x.rd = r; x.valid = v; x.done = d; x.busy = b;
    return x;
  endfunction

  int p0, d0;

  initial begin
    // Plain burst, len=3: lane i pops c(1+i)..c(3+i), valid two cycles later, done at c8.
    tbl[0]  = mk(1, 3, 4'h0, 4'h0, 4'h0, 0, 0);
    tbl[1]  = mk(0, 0, 4'h0, 4'h1, 4'h0, 0, 1);
    tbl[2]  = mk(0, 0, 4'h0, 4'h3, 4'h0, 0, 1);
    tbl[3]  = mk(0, 0, 4'h0, 4'h7, 4'h1, 0, 1);
    tbl[4]  = mk(0, 0, 4'h0, 4'hE, 4'h3, 0, 1);
    tbl[5]  = mk(0, 0, 4'h0, 4'hC, 4'h7, 0, 1);
    tbl[6]  = mk(0, 0, 4'h0, 4'h8, 4'hE, 0, 1);
    tbl[7]  = mk(0, 0, 4'h0, 4'h0, 4'hC, 0, 1);
    tbl[8]  = mk(0, 0, 4'h0, 4'h0, 4'h8, 1, 1);
    // Same burst, lane2 empty in c3 (stall bubble) and a stray start in c2 that is ignored.
    tbl[9]  = mk(1, 3, 4'h0, 4'h0, 4'h0, 0, 0);
    tbl[10] = mk(0, 0, 4'h0, 4'h1, 4'h0, 0, 1);
    tbl[11] = mk(1, 5, 4'h0, 4'h3, 4'h0, 0, 1);
    tbl[12] = mk(0, 0, 4'h4, 4'h0, 4'h1, 0, 1);
    tbl[13] = mk(0, 0, 4'h0, 4'h7, 4'h3, 0, 1);
    tbl[14] = mk(0, 0, 4'h0, 4'hE, 4'h0, 0, 1);
    tbl[15] = mk(0, 0, 4'h0, 4'hC, 4'h7, 0, 1);
    tbl[16] = mk(0, 0, 4'h0, 4'h8, 4'hE, 0, 1);
    tbl[17] = mk(0, 0, 4'h0, 4'h0, 4'hC, 0, 1);
    tbl[18] = mk(0, 0, 4'h0, 4'h0, 4'h8, 1, 1);
    // len=0: straight to DONE, no pops.
    tbl[19] = mk(1, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    tbl[20] = mk(0, 0, 4'h0, 4'h0, 4'h0, 1, 1);
    tbl[21] = mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 0);

    reset = 1'b1; start = 1'b0; len = '0; fifo_empty = '0;
    #2;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_valid", 32'(pe_valid), 32'h0);
    chk("reset_rd", 32'(fifo_rd), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int r = 0; r < NROWS; r++) begin
      @(negedge clk);
      start = tbl[r].start; len = tbl[r].len; fifo_empty = tbl[r].empty;
      #1;
      chk($sformatf("r%0d fifo_rd", r), 32'(fifo_rd), 32'(tbl[r].rd));
      chk($sformatf("r%0d pe_valid", r), 32'(pe_valid), 32'(tbl[r].valid));
      chk($sformatf("r%0d done", r), 32'(done), 32'(tbl[r].done));
      chk($sformatf("r%0d busy", r), 32'(busy), 32'(tbl[r].busy));
      check_data();
    end
    chk("pop_count", 32'(pops), 32'd24);
    chk("done_count", 32'(done_cnt), 32'd3);

    // Reset in the middle of a burst (t=2).
    @(negedge clk);
    start = 1'b1; len = 4'd3;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (c < 3) check_data();
    end
    chk("pre_reset_valid", 32'(pe_valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_rd", 32'(fifo_rd), 32'h0);
    chk("abort_valid", 32'(pe_valid), 32'h0);
    chk("abort_data", pe_data, 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_idx = rdptr;
    p0 = pops; d0 = done_cnt;
    start = 1'b1; len = 4'd3;
    #1;
    chk("post_reset_idle", 32'(busy), 32'h0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      check_data();
    end
    chk("restart_pops", 32'(pops - p0), 32'd12);
    chk("restart_done", 32'(done_cnt - d0), 32'd1);
    chk("restart_idle", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
